// File: rtl/sm4_tx_packer.sv
// -----------------------------------------------------------------------------
// sm4_tx_packer
//
// Transmit-side packer between the SM4 core and uart_tx. A 128-bit ciphertext
// block is taken over a valid/ready handshake and sent as 16 bytes, most
// significant byte first. Each byte is presented to uart_tx as a PULSE_W-cycle
// tx_pdvalid strobe with tx_pdata. The next byte is not sent until uart_tx
// returns tx_done. A watchdog aborts the block when uart_tx stops responding.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   blk_valid    upstream block valid
//   blk_data     128-bit ciphertext block, [127:120] sent first
//   blk_ready    high while a new block can be accepted (state == IDLE)
//   tx_pdvalid   registered byte strobe to uart_tx
//   tx_pdata     registered byte to uart_tx, held between strobes
//   tx_done      one-cycle byte-complete pulse from uart_tx
//   busy         high while a block is in progress
//   err_timeout  registered one-cycle pulse when a block is aborted
// -----------------------------------------------------------------------------
module sm4_tx_packer #(
   parameter int NUM_BYTES   = 16,
   parameter int PULSE_W     = 4,
   parameter int TIMEOUT_CYC = 70000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         blk_valid,
   input  logic [127:0] blk_data,
   output logic         blk_ready,
   output logic         tx_pdvalid,
   output logic [7:0]   tx_pdata,
   input  logic         tx_done,
   output logic         busy,
   output logic         err_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   localparam logic [3:0]  BYTE_LAST  = 4'(NUM_BYTES - 1);
   localparam logic [15:0] PULSE_LAST = 16'(PULSE_W - 1);
   localparam logic [19:0] WD_LAST    = 20'(TIMEOUT_CYC - 1);

   state_t         state;
   state_t         state_nxt;
   logic [127:0]   shift_reg;
   logic [127:0]   shift_nxt;
   logic [3:0]     byte_cnt;
   logic [3:0]     byte_cnt_nxt;
   logic [15:0]    pulse_cnt;
   logic [15:0]    pulse_nxt;
   logic [19:0]    wd_cnt;
   logic [19:0]    wd_nxt;
   logic           pdvalid_nxt;
   logic [7:0]     pdata_nxt;
   logic           err_nxt;

   logic           accept;
   logic           pulse_last;
   logic           byte_last;
   logic           wd_hit;

   assign accept     = blk_valid && (state == ST_IDLE);
   assign pulse_last = (pulse_cnt == PULSE_LAST);
   assign byte_last  = (byte_cnt == BYTE_LAST);
   assign wd_hit     = (wd_cnt == WD_LAST);

   assign blk_ready  = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; in WAIT a tx_done in the timeout cycle takes priority.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_STROBE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_STROBE: begin
            if (wd_hit) begin
               state_nxt = ST_IDLE;
            end else if (pulse_last) begin
               state_nxt = ST_WAIT;
            end else begin
               state_nxt = ST_STROBE;
            end
         end
         ST_WAIT: begin
            if (tx_done) begin
               state_nxt = byte_last ? ST_IDLE : ST_STROBE;
            end else if (wd_hit) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_WAIT;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output and datapath decode: next values of every registered output,
   // the shift register and the counters.
   always_comb begin
      shift_nxt    = shift_reg;
      byte_cnt_nxt = byte_cnt;
      pulse_nxt    = pulse_cnt;
      wd_nxt       = wd_cnt;
      pdata_nxt    = tx_pdata;
      pdvalid_nxt  = 1'b0;
      err_nxt      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               shift_nxt    = blk_data;
               byte_cnt_nxt = 4'd0;
               pulse_nxt    = 16'd0;
               wd_nxt       = 20'd0;
               pdata_nxt    = blk_data[127:120];
               pdvalid_nxt  = 1'b1;
            end else begin
               pdvalid_nxt  = 1'b0;
            end
         end
         ST_STROBE: begin
            if (wd_hit) begin
               err_nxt     = 1'b1;
               wd_nxt      = 20'd0;
               pdvalid_nxt = 1'b0;
            end else if (pulse_last) begin
               wd_nxt      = wd_cnt + 20'd1;
               pdvalid_nxt = 1'b0;
            end else begin
               wd_nxt      = wd_cnt + 20'd1;
               pulse_nxt   = pulse_cnt + 16'd1;
               pdvalid_nxt = 1'b1;
            end
         end
         ST_WAIT: begin
            if (tx_done && byte_last) begin
               wd_nxt       = 20'd0;
               pdvalid_nxt  = 1'b0;
            end else if (tx_done) begin
               // Next byte sits at [119:112] before the shift lands.
               shift_nxt    = {shift_reg[119:0], 8'h00};
               byte_cnt_nxt = byte_cnt + 4'd1;
               pulse_nxt    = 16'd0;
               wd_nxt       = 20'd0;
               pdata_nxt    = shift_reg[119:112];
               pdvalid_nxt  = 1'b1;
            end else if (wd_hit) begin
               err_nxt      = 1'b1;
               wd_nxt       = 20'd0;
               pdvalid_nxt  = 1'b0;
            end else begin
               wd_nxt       = wd_cnt + 20'd1;
               pdvalid_nxt  = 1'b0;
            end
         end
         default: begin
            pdvalid_nxt = 1'b0;
            err_nxt     = 1'b0;
         end
      endcase
   end

   // Datapath and registered-output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg   <= 128'd0;
         byte_cnt    <= 4'd0;
         pulse_cnt   <= 16'd0;
         wd_cnt      <= 20'd0;
         tx_pdvalid  <= 1'b0;
         tx_pdata    <= 8'h00;
         err_timeout <= 1'b0;
      end else begin
         shift_reg   <= shift_nxt;
         byte_cnt    <= byte_cnt_nxt;
         pulse_cnt   <= pulse_nxt;
         wd_cnt      <= wd_nxt;
         tx_pdvalid  <= pdvalid_nxt;
         tx_pdata    <= pdata_nxt;
         err_timeout <= err_nxt;
      end
   end

endmodule

// File: doc/sm4_tx_packer.md
# sm4_tx_packer

Transmit-side packer between the SM4 core and the UART transmitter (`uart_tx`). It accepts one 128-bit ciphertext block through a valid/ready handshake and splits it into 16 bytes, most significant byte first. Each byte is handed to `uart_tx` as a `tx_pdvalid` strobe with `tx_pdata`, and the block waits for `tx_done` before sending the next byte. A watchdog aborts the block if `uart_tx` stops responding.

## Interface
Parameters:
- `NUM_BYTES`, 16: bytes per block. Fixed to 16 for a 128-bit block.
- `PULSE_W`, 4: cycles `tx_pdvalid` is held high per byte. Minimum 2.
- `TIMEOUT_CYC`, 70000: maximum cycles from the start of a strobe to `tx_done`. Must be less than 2^20.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `blk_valid`  in  1  upstream block valid.
- `blk_data`  in  128  ciphertext block; `[127:120]` is sent first.
- `blk_ready`  out  1  high when a block can be accepted.
- `tx_pdvalid`  out  1  byte strobe to `uart_tx`.
- `tx_pdata`  out  8  byte to `uart_tx`.
- `tx_done`  in  1  one-cycle byte-complete pulse from `uart_tx`.
- `busy`  out  1  high while a block is in progress.
- `err_timeout`  out  1  one-cycle pulse when a block is aborted.

## Operation
- State register: IDLE, STROBE, WAIT.
- IDLE:
  - `blk_ready`=1.
  - On `blk_valid & blk_ready`: load `blk_data` into a 128-bit shift register, clear `byte_cnt` (4 bit), clear `pulse_cnt` and `wd_cnt`, go to STROBE.
- STROBE:
  - `tx_pdata` = shift register `[127:120]`; `tx_pdvalid`=1.
  - `pulse_cnt` counts to `PULSE_W`-1, then go to WAIT with `tx_pdvalid`=0.
  - `tx_done` is ignored in this state.
- WAIT:
  - `tx_pdvalid`=0; `tx_pdata` is held.
  - On `tx_done` with `byte_cnt`==`NUM_BYTES`-1: go to IDLE.
  - On `tx_done` otherwise: shift left by 8, `byte_cnt`+1, clear `pulse_cnt` and `wd_cnt`, go to STROBE.
- Watchdog:
  - `wd_cnt` (20 bit) increments every cycle in STROBE and WAIT.
  - When it reaches `TIMEOUT_CYC`-1 without `tx_done`: pulse `err_timeout`, drop the remaining bytes, go to IDLE.
  - If `tx_done` and the timeout coincide, `tx_done` wins and no error is raised.
- `busy` = (state != IDLE). `blk_ready` = (state == IDLE).
- `blk_valid` is ignored while not in IDLE. Upstream holds `blk_valid` and `blk_data` until accepted.
- `tx_done` in IDLE is ignored.

## Timing
- All outputs are registered, except `blk_ready` and `busy`, which are decoded from the state register.
- Reset values: state IDLE, `tx_pdvalid`=0, `tx_pdata`=0x00, `err_timeout`=0, `busy`=0, `blk_ready`=1. All counters and the shift register are 0.
- Asserting `rst_n` mid-block forces the reset values immediately. The block does not resume after reset is released.
- Block accepted at cycle T:
  - `tx_pdvalid` is high on cycles T+1 to T+`PULSE_W`.
  - `tx_pdata` is valid from T+1 and stable until the next byte load.
- Byte handoff: `tx_done` sampled at cycle D → next strobe starts at D+1. `tx_pdvalid` has been low for at least 1 cycle before each rising edge.
- Block end: the last `tx_done` at cycle D → `blk_ready`=1 at D+1. A new block can be accepted at D+1.
- Timeout: `err_timeout` is high for 1 cycle, `TIMEOUT_CYC` cycles after the strobe start. The state is IDLE on the following cycle.

## Test plan
- Reset: assert `rst_n`=0 → `tx_pdvalid`=0, `tx_pdata`=0x00, `busy`=0, `err_timeout`=0, `blk_ready`=1.
- Single block: `blk_data`=0x00112233445566778899AABBCCDDEEFF, with a `tx_done` model responding 40 cycles after each strobe rise → 16 strobes each 4 cycles wide, bytes 00,11,…,FF in order, `busy`=1 throughout, `blk_ready`=1 the cycle after the 16th `tx_done`.
- Back-to-back and backpressure:
  - Second block presented while busy → not accepted until `blk_ready`=1, its first strobe one cycle after acceptance.
  - Spurious `tx_done` in IDLE and in STROBE → no state change.
- Timeout: `TIMEOUT_CYC`=200, `tx_done` withheld after byte 3 → `err_timeout` pulses exactly 200 cycles after the byte-4 strobe start, no byte-5 strobe, `blk_ready`=1 the next cycle.
- Reset mid-block: `rst_n` pulled low during WAIT of byte 6 → reset values immediately; after release no strobe until a new `blk_valid`.
- Integration with a real `uart_tx` instance (`CLK_F`/`UART_B`=16) → the serial line decodes the 16 bytes in MSB-first block order with no dropped or repeated bytes.
